// File: rtl/ex_period_meter.sv
// Period / high-time meter for a slow square wave sampled in the safe_clk domain.
// Reports each completed rise-to-rise period, checks it against a tolerance window, and flags a stuck input.
module ex_period_meter #(
    parameter int CNT_W      = 21,
    parameter int EXP_PERIOD = 1_000_001,
    parameter int TOL        = 1_000,
    parameter int TIMEOUT    = 2_000_000
) (
    input  logic             safe_clk,
    input  logic             safe_reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] high_cycles,
    output logic             meas_valid,
    output logic             period_ok,
    output logic             stuck
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   ext_t;
    typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

    localparam cnt_t TIMEOUT_C = cnt_t'(TIMEOUT);
    localparam cnt_t ONE_C     = cnt_t'(1);
    localparam ext_t EXP_C     = ext_t'(EXP_PERIOD);
    localparam ext_t TOL_C     = ext_t'(TOL);

    logic   sync1_q, sync2_q, prev_q;
    cnt_t   cnt_q, cnt_d;
    cnt_t   hcnt_q, hcnt_d;
    cnt_t   period_q, high_q;
    logic   valid_q, ok_q, stuck_q;
    state_t state_q;

    logic              rise;
    logic              timeout_hit;
    logic signed [CNT_W:0] diff;
    ext_t              abs_diff;
    logic              in_tol;

    assign rise        = sync2_q & ~prev_q;
    assign timeout_hit = (cnt_q == TIMEOUT_C);

    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = ONE_C;
            hcnt_d = ONE_C;
        end else begin
            // Both counters stick at TIMEOUT so a dead input can never wrap into a fake period.
            if (!timeout_hit)
                cnt_d = cnt_q + ONE_C;
            if (sync2_q && (hcnt_q != TIMEOUT_C))
                hcnt_d = hcnt_q + ONE_C;
        end
    end

    always_comb begin
        diff     = $signed({1'b0, cnt_q}) - $signed(EXP_C);
        abs_diff = diff[CNT_W] ? ext_t'(-diff) : ext_t'(diff);
        in_tol   = (abs_diff <= TOL_C);
    end

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            stuck_q  <= 1'b0;
            state_q  <= IDLE;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= MEAS;
                    end else if (timeout_hit) begin
                        state_q <= STUCK;
                        stuck_q <= 1'b1;
                        ok_q    <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        ok_q     <= in_tol;
                        valid_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= STUCK;
                        stuck_q <= 1'b1;
                        ok_q    <= 1'b0;
                    end
                end
                STUCK: begin
                    // The period spanning the stuck interval is discarded; this rise is only a reference.
                    if (rise) begin
                        state_q <= MEAS;
                        stuck_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period_cycles = period_q;
    assign high_cycles   = high_q;
    assign meas_valid    = valid_q;
    assign period_ok     = ok_q;
    assign stuck         = stuck_q;

endmodule

// File: tb/tb_ex_period_meter.sv
// Self-checking bench for ex_period_meter: constant vector table, hand-written corner sequences,
// and a randomized waveform phase checked every cycle against an event-level reference model.
`timescale 1ns/1ps
module tb_ex_period_meter;

    localparam int CNT_W      = 6;
    localparam int EXP_PERIOD = 10;
    localparam int TOL        = 1;
    localparam int TIMEOUT    = 32;
    localparam int NVEC       = 19;

    logic             safe_clk = 1'b0;
    logic             safe_reset_n = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_cycles;
    logic [CNT_W-1:0] high_cycles;
    logic             meas_valid;
    logic             period_ok;
    logic             stuck;

    ex_period_meter #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)
    ) dut (
        .safe_clk(safe_clk),
        .safe_reset_n(safe_reset_n),
        .sig_in(sig_in),
        .period_cycles(period_cycles),
        .high_cycles(high_cycles),
        .meas_valid(meas_valid),
        .period_ok(period_ok),
        .stuck(stuck)
    );

    always #5 safe_clk = ~safe_clk;

    typedef struct { int hi; int lo; int p; int h; bit ok; } vec_t;
    typedef struct { int p; int h; bit ok; } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   valid_count = 0;
    int   since_valid = 0;
    obs_t obs[$];
    vec_t tbl[NVEC];

    // Reference model: samp[e] is sig_in as sampled at edge e after reset release (samp[0] = reset value).
    int  samp[$];
    int  ref_t;
    bit  have_ref;
    int  m_period, m_high;
    bit  m_valid, m_ok, m_stuck;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        samp.push_back(0);
        ref_t    = -1;
        have_ref = 1'b0;
        m_period = 0;
        m_high   = 0;
        m_valid  = 1'b0;
        m_ok     = 1'b0;
        m_stuck  = 1'b0;
    endtask

    // A sample taken at edge s shows up on the outputs after edge s+2.
    task automatic model_step(input bit v);
        int s;
        int d;
        samp.push_back(int'(v));
        s = samp.size() - 3;
        m_valid = 1'b0;
        if (s >= 1) begin
            if (samp[s] == 1 && samp[s-1] == 0) begin
                if (have_ref && !m_stuck) begin
                    m_period = s - ref_t;
                    m_high   = 0;
                    for (int i = ref_t; i < s; i++) m_high += samp[i];
                    d = (m_period > EXP_PERIOD) ? m_period - EXP_PERIOD : EXP_PERIOD - m_period;
                    m_ok    = (d <= TOL);
                    m_valid = 1'b1;
                end
                m_stuck  = 1'b0;
                ref_t    = s;
                have_ref = 1'b1;
            end else if (!m_stuck && (s - ref_t == TIMEOUT)) begin
                m_stuck = 1'b1;
                m_ok    = 1'b0;
            end
        end
    endtask

    task automatic tick(input bit v);
        sig_in = v;
        @(posedge safe_clk);
        model_step(v);
        #1;
        chk("model period_cycles", int'(period_cycles), m_period);
        chk("model high_cycles", int'(high_cycles), m_high);
        chk("model meas_valid", int'(meas_valid), int'(m_valid));
        chk("model period_ok", int'(period_ok), int'(m_ok));
        chk("model stuck", int'(stuck), int'(m_stuck));
        if (meas_valid) begin
            valid_count++;
            since_valid = 0;
            obs.push_back('{int'(period_cycles), int'(high_cycles), period_ok});
            $display("meas: period=%0d high=%0d ok=%0d stuck=%0d (t=%0t)",
                     period_cycles, high_cycles, period_ok, stuck, $time);
        end else begin
            since_valid++;
        end
    endtask

    // Reset is asserted 3 ns after a rising edge and released mid-low-phase, off the clock edges.
    task automatic do_reset();
        @(posedge safe_clk);
        #3 safe_reset_n = 1'b0;
        #1;
        chk("reset period_cycles", int'(period_cycles), 0);
        chk("reset high_cycles", int'(high_cycles), 0);
        chk("reset meas_valid", int'(meas_valid), 0);
        chk("reset period_ok", int'(period_ok), 0);
        chk("reset stuck", int'(stuck), 0);
        repeat (2) @(posedge safe_clk);
        @(negedge safe_clk);
        #2 safe_reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        int hi, lo;

        tbl[0]  = '{4, 6, 10, 4, 1'b1};
        tbl[1]  = '{4, 6, 10, 4, 1'b1};
        tbl[2]  = '{4, 6, 10, 4, 1'b1};
        tbl[3]  = '{4, 5,  9, 4, 1'b1};
        tbl[4]  = '{4, 7, 11, 4, 1'b1};
        tbl[5]  = '{4, 8, 12, 4, 1'b0};
        tbl[6]  = '{4, 4,  8, 4, 1'b0};
        for (int h = 1; h <= 9; h++) tbl[6+h] = '{h, 10-h, 10, h, 1'b1};
        tbl[16] = '{1, 1,  2, 1, 1'b0};
        tbl[17] = '{20, 12, 32, 20, 1'b0};
        tbl[18] = '{5, 5, 10, 5, 1'b1};

        model_reset();
        do_reset();

        // Vector table: first rise is a reference, each later rise reports the preceding entry.
        obs.delete();
        for (int i = 0; i < NVEC; i++) begin
            repeat (tbl[i].hi) tick(1'b1);
            repeat (tbl[i].lo) tick(1'b0);
        end
        tick(1'b1);
        repeat (3) tick(1'b0);
        chk("table measurement count", obs.size(), NVEC);
        for (int i = 0; i < NVEC && i < obs.size(); i++) begin
            chk($sformatf("table[%0d] period", i), obs[i].p, tbl[i].p);
            chk($sformatf("table[%0d] high", i), obs[i].h, tbl[i].h);
            chk($sformatf("table[%0d] ok", i), int'(obs[i].ok), int'(tbl[i].ok));
        end

        // Stuck after a valid period, then recovery and rise-to-valid latency.
        do_reset();
        repeat (2) begin
            repeat (4) tick(1'b1);
            repeat (6) tick(1'b0);
        end
        repeat (4) tick(1'b1);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            if (since_valid == 31) chk("stuck one cycle early", int'(stuck), 0);
            if (since_valid == 32) begin
                chk("stuck at timeout", int'(stuck), 1);
                chk("stuck holds period", int'(period_cycles), 10);
                chk("stuck forces period_ok", int'(period_ok), 0);
            end
        end
        vc = valid_count;
        repeat (4) tick(1'b1);
        repeat (6) tick(1'b0);
        chk("no valid on stuck exit", valid_count - vc, 0);
        chk("stuck cleared by rise", int'(stuck), 0);
        tick(1'b1);
        chk("latency edge 1 valid", int'(meas_valid), 0);
        tick(1'b1);
        chk("latency edge 2 valid", int'(meas_valid), 0);
        tick(1'b1);
        chk("latency edge 3 valid", int'(meas_valid), 1);
        chk("latency period", int'(period_cycles), 10);
        chk("latency high", int'(high_cycles), 4);
        chk("latency ok", int'(period_ok), 1);
        tick(1'b1);
        repeat (6) tick(1'b0);

        // Reset in the middle of a period.
        repeat (4) tick(1'b1);
        repeat (3) tick(1'b0);
        do_reset();
        vc = valid_count;
        repeat (4) tick(1'b1);
        repeat (6) tick(1'b0);
        chk("no valid on first rise after reset", valid_count - vc, 0);
        repeat (4) tick(1'b1);
        repeat (6) tick(1'b0);
        chk("valid after second rise", valid_count - vc, 1);
        if (obs.size() > 0) chk("post-reset period", obs[obs.size()-1].p, 10);

        // No edge at all after reset.
        do_reset();
        for (int i = 1; i <= 34; i++) begin
            tick(1'b0);
            if (i == 32) chk("idle stuck early", int'(stuck), 0);
            if (i == 33) chk("idle stuck at timeout", int'(stuck), 1);
        end

        // Constant-high input after reset.
        do_reset();
        vc = valid_count;
        repeat (45) tick(1'b1);
        chk("const high no valid", valid_count - vc, 0);
        chk("const high stuck", int'(stuck), 1);
        chk("const high high_cycles", int'(high_cycles), 0);
        repeat (3) tick(1'b0);

        // Randomized waveform, occasionally with lows long enough to straddle the timeout.
        repeat (80) begin
            hi = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) lo = $urandom_range(27, 40);
            else                           lo = $urandom_range(1, 9);
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
